sad_ctrl: RTL and testbench

- Sequencer that time-shares one `abs_dif` datapath (N-bit |a−b|) across a stream of operand pairs.
- Accumulates a sum of absolute differences (SAD) over a block of LEN pairs.
- Start/done handshake toward the host; valid/ready handshake toward the operand source.
- Sits between an operand buffer and any consumer of SAD results, e.g. a block-match or compare stage.

---
 rtl/sad_ctrl_pkg.sv | 21 ++
 rtl/abs_dif.sv | 14 +
 rtl/sad_ctrl.sv | 128 ++++++++++++
 tb/tb_sad_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sad_ctrl_pkg.sv
// Shared definitions for the SAD sequencer: FSM state encoding and a constant clog2.
package sad_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Smallest r with 2**r >= v; usable in parameter/localparam expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/abs_dif.sv
// Combinational N-bit absolute difference |a - b|.
module abs_dif #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] dif_c
);

  always_comb begin
    dif_c = (a >= b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/sad_ctrl.sv
// Sum-of-absolute-differences sequencer: accepts LEN operand pairs per block through
// one shared abs_dif, accumulates them and reports the sum with a one-cycle done pulse.
module sad_ctrl
  import sad_ctrl_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned LEN   = 8,
  localparam int unsigned ACC_W = N + clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sad_out
);

  localparam int unsigned CNT_W = (clog2(LEN) > 0) ? clog2(LEN) : 1;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [N-1:0]     op_a_q,     op_a_d;
  logic [N-1:0]     op_b_q,     op_b_d;
  logic             op_vld_q,   op_vld_d;
  logic [ACC_W-1:0] acc_q,      acc_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [N-1:0]     dif_c;
  logic             xfer_c;

  abs_dif #(.N(N)) u_abs_dif (
    .a     (op_a_q),
    .b     (op_b_q),
    .dif_c (dif_c)
  );

  // in_ready depends only on state, so the transfer never loops back through in_valid.
  assign xfer_c = in_valid && (state_q == S_RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_vld_d = 1'b0;
    acc_d    = acc_q;

    if (op_vld_q) acc_d = acc_q + ACC_W'(dif_c);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (xfer_c) begin
          op_a_d   = a_in;
          op_b_d   = b_in;
          op_vld_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LEN - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_RUN);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_vld_q   <= 1'b0;
      acc_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_vld_q   <= op_vld_d;
      acc_q      <= acc_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sad_out  = acc_q;

endmodule

// File: tb/tb_sad_ctrl.sv
// Randomised block-level bench for sad_ctrl; expected sums and cycle timing come from
// a plain arithmetic model of accepted pairs.
module tb_sad_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned LEN   = 8;
  localparam int unsigned ACC_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] sad_out;

  int n_chk = 0;
  int n_bad = 0;
  int pa[LEN];
  int pb[LEN];

  always #5 clk = ~clk;

  sad_ctrl #(.N(N), .LEN(LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .sad_out  (sad_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  task automatic chk_idle(input string tag, input int exp_sad);
    chk({tag, "_rdy"},  32'(in_ready), 0);
    chk({tag, "_busy"}, 32'(busy),     0);
    chk({tag, "_done"}, 32'(done),     0);
    chk({tag, "_sad"},  32'(sad_out),  32'(exp_sad));
  endtask

  task automatic fill_const(input int a, input int b);
    for (int i = 0; i < LEN; i++) begin
      pa[i] = a;
      pb[i] = b;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < LEN; i++) begin
      pa[i] = int'($urandom_range(0, 15));
      pb[i] = int'($urandom_range(0, 15));
    end
  endtask

  // gap_mode: 0 valid always, 1 valid every other cycle, 2 random valid.
  // abort_at/rst_at: handshake count at which to interrupt (LEN aborts in DRAIN, -1 none).
  task automatic run_block(input int gap_mode, input int abort_at, input int rst_at,
                           input bit pokes);
    int exp_sum;
    int hs;
    int iter;
    bit v;
    bit intr;
    exp_sum = 0;
    hs      = 0;
    iter    = 0;

    // start with a pair already valid: that pair must not be accepted
    start    = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b1;
    a_in     = N'($urandom);
    b_in     = N'($urandom);
    tick();
    start = 1'b0;

    while (hs < LEN) begin
      chk("run_rdy",  32'(in_ready), 1);
      chk("run_busy", 32'(busy),     1);
      chk("run_done", 32'(done),     0);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (iter % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (iter > 4 * LEN + 20) v = 1'b1;
      in_valid = v;
      a_in     = v ? N'(pa[hs]) : N'($urandom);
      b_in     = v ? N'(pb[hs]) : N'($urandom);
      start    = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
      abort    = (hs == abort_at);
      rst      = (hs == rst_at);
      intr     = abort || rst;
      tick();
      iter++;
      if (intr) begin
        abort    = 1'b0;
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        chk_idle("intr", 0);
        tick();
        chk_idle("intr_hold", 0);
        return;
      end
      if (v) begin
        exp_sum += absd(pa[hs], pb[hs]);
        hs++;
      end
    end

    chk("drain_rdy",  32'(in_ready), 0);
    chk("drain_busy", 32'(busy),     1);
    chk("drain_done", 32'(done),     0);
    in_valid = 1'($urandom_range(0, 1));
    start    = pokes;
    abort    = (abort_at == LEN);
    intr     = abort;
    tick();
    abort = 1'b0;
    if (intr) begin
      start = 1'b0;
      chk_idle("drain_abort", 0);
      tick();
      chk_idle("drain_abort_hold", 0);
      return;
    end

    chk("done_pulse", 32'(done),     1);
    chk("done_busy",  32'(busy),     1);
    chk("done_rdy",   32'(in_ready), 0);
    chk("done_sad",   32'(sad_out),  32'(exp_sum));
    start    = pokes;
    in_valid = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    chk_idle("post_done", exp_sum);
    tick();
    chk_idle("post_hold", exp_sum);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'($urandom_range(0, 1));
    abort    = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    a_in     = N'($urandom);
    b_in     = N'($urandom);
    tick();
    chk_idle("reset0", 0);
    start    = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
    tick();
    chk_idle("reset1", 0);
    rst      = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_idle("idle", 0);

    pa = '{9, 2, 15, 5, 0, 4, 1, 8};
    pb = '{3, 7, 0, 5, 15, 1, 4, 8};
    run_block(0, -1, -1, 1'b0);

    fill_const(15, 0);
    run_block(1, -1, -1, 1'b0);

    fill_const(7, 2);
    run_block(0, 3, -1, 1'b0);
    fill_const(1, 0);
    run_block(0, -1, -1, 1'b0);

    fill_rand();
    run_block(2, -1, -1, 1'b1);

    fill_const(3, 5);
    run_block(0, -1, 5, 1'b0);
    run_block(0, -1, -1, 1'b0);

    fill_rand();
    run_block(2, LEN, -1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_rand();
      run_block(int'($urandom_range(0, 2)), -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
